// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the two-requester memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam int LINE_WORDS_DEF = 4;
    localparam int MAX_OUTST_DEF  = 4;

endpackage

// File: rtl/mem_burst_counter.sv
// Beat index and in-flight bookkeeping for one line burst.
module mem_burst_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int LINE_WORDS = LINE_WORDS_DEF,
    parameter int MAX_OUTST  = MAX_OUTST_DEF,
    localparam int IDX_W = $clog2(LINE_WORDS),
    localparam int OUT_W = $clog2(MAX_OUTST) + 1,
    localparam int RET_W = IDX_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             issue,
    input  logic             issue_rd,
    input  logic             ret,
    output logic [IDX_W-1:0] beat_idx,
    output logic             last_beat,
    output logic             full,
    output logic             all_returned
);

    logic [OUT_W-1:0] outstanding;
    logic [RET_W-1:0] returned;

    // Advance the beat index per accepted beat and track read beats still in flight.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            beat_idx    <= '0;
            outstanding <= '0;
            returned    <= '0;
        end else begin
            if (issue) begin
                beat_idx <= beat_idx + IDX_W'(1);
            end
            outstanding <= outstanding + OUT_W'(issue_rd) - OUT_W'(ret);
            if (ret) begin
                returned <= returned + RET_W'(1);
            end
        end
    end

    assign last_beat    = (beat_idx == IDX_W'(LINE_WORDS - 1));
    assign full         = (outstanding == OUT_W'(MAX_OUTST));
    assign all_returned = ((returned + RET_W'(ret)) == RET_W'(LINE_WORDS));

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin burst arbiter sharing one memory port between I-cache and D-cache.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int LINE_WORDS = LINE_WORDS_DEF,
    parameter int MAX_OUTST  = MAX_OUTST_DEF,
    localparam int IDX_W = $clog2(LINE_WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_rvalid,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_rvalid,
    output logic              d_done,
    output logic [DATA_W-1:0] rdata,
    output logic [IDX_W-1:0]  beat_idx,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rdy,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(LINE_WORDS - 1);

    state_t            state;
    owner_t            owner;
    owner_t            last;
    logic              dir_we;
    logic [ADDR_W-1:0] base;
    logic              fire;
    logic              ret;
    logic              grant_d;
    logic              last_beat;
    logic              full;
    logic              all_returned;

    // Reads stall issue while the outstanding window is full; writes never do.
    assign mem_req   = (state == ISSUE) && !(!dir_we && full);
    assign mem_we    = (state == ISSUE) && dir_we;
    assign mem_addr  = base | ADDR_W'(beat_idx);
    assign mem_wdata = d_wdata;
    assign fire      = mem_req && mem_rdy;

    // Returns only count while a read burst is live; stray beats are dropped.
    assign ret      = mem_rvalid && !dir_we && ((state == ISSUE) || (state == DRAIN));
    assign rdata    = mem_rdata;
    assign i_rvalid = ret && (owner == OWN_I);
    assign d_rvalid = ret && (owner == OWN_D);
    assign i_done   = (state == DONE) && (owner == OWN_I);
    assign d_done   = (state == DONE) && (owner == OWN_D);

    // On a tie the side that did not own the previous burst wins.
    assign grant_d = d_req && (!i_req || (last == OWN_I));

    mem_burst_counter #(
        .LINE_WORDS (LINE_WORDS),
        .MAX_OUTST  (MAX_OUTST)
    ) u_counter (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (state == IDLE),
        .issue        (fire),
        .issue_rd     (fire && !dir_we),
        .ret          (ret),
        .beat_idx     (beat_idx),
        .last_beat    (last_beat),
        .full         (full),
        .all_returned (all_returned)
    );

    // Burst FSM: grant and latch request, issue beats, wait for returns, pulse done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            owner  <= OWN_I;
            last   <= OWN_I;
            dir_we <= 1'b0;
            base   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        if (grant_d) begin
                            owner  <= OWN_D;
                            dir_we <= d_we;
                            base   <= d_addr & ~LOW_MASK;
                        end else begin
                            owner  <= OWN_I;
                            dir_we <= 1'b0;
                            base   <= i_addr & ~LOW_MASK;
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (fire && last_beat) begin
                        if (dir_we || all_returned) begin
                            state <= DONE;
                        end else begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (all_returned) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    last  <= owner;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
